// File: rtl/mips_multicycle.sv
// mips_multicycle: multicycle MIPS-subset core (lw, sw, R-type, beq, addi, j) with
// registered Moore memory controls. Define MIPS_EXT_OPS_EN to add andi, ori and bne.
module mips_multicycle (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] readdata,
  output logic        iord,
  output logic        memwrite,
  output logic        irwrite,
  output logic [31:0] pc,
  output logic [31:0] aluout,
  output logic [31:0] writedata
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef MIPS_EXT_OPS_EN
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
`endif

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3, ALU_SLT = 3'd4
  } aluop_t;

  state_t      state_r;
  logic        iord_r, irwrite_r, memwrite_r;
  logic [31:0] pc_r, a_r, b_r, data_r, aluout_r;
  logic [31:0] regs_r [32];

  logic [5:0]  op_s, funct_s;
  logic [4:0]  rs_s, rt_s, rd_s;
  logic [31:0] simm_s, srca_s, srcb_s, alu_y_s, wr_data_s;
  aluop_t      aluop_s;
  logic        zero_s, take_s, wr_en_s;
  logic [4:0]  wr_addr_s;

  assign op_s      = instr[31:26];
  assign rs_s      = instr[25:21];
  assign rt_s      = instr[20:16];
  assign rd_s      = instr[15:11];
  assign funct_s   = instr[5:0];
  assign simm_s    = {{16{instr[15]}}, instr[15:0]};
  assign zero_s    = (alu_y_s == 32'd0);
  assign iord      = iord_r;
  assign irwrite   = irwrite_r;
  assign memwrite  = memwrite_r;
  assign pc        = pc_r;
  assign aluout    = aluout_r;
  assign writedata = b_r;

  function automatic state_t next_state(input state_t s, input logic [5:0] op);
    state_t n;
    case (s)
      S_FETCH:  n = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_RTYPE:     n = S_EXEC;
          OP_BEQ:       n = S_BRANCH;
          OP_ADDI:      n = S_ADDIEX;
          OP_J:         n = S_JUMP;
`ifdef MIPS_EXT_OPS_EN
          OP_BNE:          n = S_BRANCH;
          OP_ANDI, OP_ORI: n = S_ADDIEX;
`endif
          default:      n = S_FETCH;
        endcase
      end
      S_MEMADR: n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  n = S_MEMWB;
      S_EXEC:   n = S_ALUWB;
      S_ADDIEX: n = S_ADDIWB;
      default:  n = S_FETCH;
    endcase
    return n;
  endfunction

  // {iord, irwrite, memwrite} as seen while sitting in state s
  function automatic logic [2:0] moore_out(input state_t s);
    logic [2:0] o;
    case (s)
      S_FETCH: o = 3'b010;
      S_MEMRD: o = 3'b100;
      S_MEMWR: o = 3'b101;
      default: o = 3'b000;
    endcase
    return o;
  endfunction

  // ALU operand and operation selection per state
  always_comb begin
    srca_s  = pc_r;
    srcb_s  = 32'd4;
    aluop_s = ALU_ADD;
    case (state_r)
      S_DECODE: srcb_s = {simm_s[29:0], 2'b00};
      S_MEMADR: begin srca_s = a_r; srcb_s = simm_s; end
      S_BRANCH: begin srca_s = a_r; srcb_s = b_r; aluop_s = ALU_SUB; end
      S_EXEC: begin
        srca_s = a_r;
        srcb_s = b_r;
        case (funct_s)
          6'h22:   aluop_s = ALU_SUB;
          6'h24:   aluop_s = ALU_AND;
          6'h25:   aluop_s = ALU_OR;
          6'h2A:   aluop_s = ALU_SLT;
          default: aluop_s = ALU_ADD;
        endcase
      end
      S_ADDIEX: begin
        srca_s = a_r;
        srcb_s = simm_s;
`ifdef MIPS_EXT_OPS_EN
        if (op_s == OP_ANDI) begin
          srcb_s  = {16'd0, instr[15:0]};
          aluop_s = ALU_AND;
        end else if (op_s == OP_ORI) begin
          srcb_s  = {16'd0, instr[15:0]};
          aluop_s = ALU_OR;
        end else begin
          aluop_s = ALU_ADD;
        end
`endif
      end
      default: begin srca_s = pc_r; srcb_s = 32'd4; end
    endcase
  end

  // ALU: wrap-around arithmetic, signed set-less-than
  always_comb begin
    case (aluop_s)
      ALU_SUB: alu_y_s = srca_s - srcb_s;
      ALU_AND: alu_y_s = srca_s & srcb_s;
      ALU_OR:  alu_y_s = srca_s | srcb_s;
      ALU_SLT: alu_y_s = {31'd0, ($signed(srca_s) < $signed(srcb_s))};
      default: alu_y_s = srca_s + srcb_s;
    endcase
  end

  // branch condition: beq on zero, bne on non-zero
  always_comb begin
`ifdef MIPS_EXT_OPS_EN
    if (op_s == OP_BNE) take_s = ~zero_s;
    else                take_s = zero_s;
`else
    take_s = zero_s;
`endif
  end

  // register-file write port selection for the write-back states
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = rt_s;
    wr_data_s = aluout_r;
    case (state_r)
      S_MEMWB:  begin wr_en_s = 1'b1; wr_data_s = data_r; end
      S_ALUWB:  begin wr_en_s = 1'b1; wr_addr_s = rd_s; end
      S_ADDIWB: wr_en_s = 1'b1;
      default:  wr_en_s = 1'b0;
    endcase
  end

  // controller FSM with outputs registered for the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r                           <= S_FETCH;
      {iord_r, irwrite_r, memwrite_r}   <= 3'b010;
    end else begin
      state_r                           <= next_state(state_r, op_s);
      {iord_r, irwrite_r, memwrite_r}   <= moore_out(next_state(state_r, op_s));
    end
  end

  // datapath registers and PC update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r     <= 32'd0;
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      data_r   <= 32'd0;
      aluout_r <= 32'd0;
    end else begin
      a_r      <= regs_r[rs_s];
      b_r      <= regs_r[rt_s];
      data_r   <= readdata;
      aluout_r <= alu_y_s;
      if (state_r == S_FETCH)                pc_r <= alu_y_s;
      else if (state_r == S_BRANCH && take_s) pc_r <= aluout_r;
      else if (state_r == S_JUMP)            pc_r <= {pc_r[31:28], instr[25:0], 2'b00};
      else                                   pc_r <= pc_r;
    end
  end

  // register file; entry 0 is never written so it always reads zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_r[i] <= 32'd0;
    end else if (wr_en_s && (wr_addr_s != 5'd0)) begin
      regs_r[wr_addr_s] <= wr_data_s;
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: directed + random programs run on the core against an
// instruction-level reference model (per-instruction PC, cycle count, stores).
module tb_mips_multicycle;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'd0;
  logic [31:0] readdata;
  logic        iord, memwrite, irwrite;
  logic [31:0] pc, aluout, writedata;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] ref_reg [32];
  logic [31:0] ref_pc;
  logic [31:0] end_pc;
  int checks = 0;
  int passes = 0;
  int wp;

  mips_multicycle dut (
    .clk(clk), .reset(reset), .instr(instr), .readdata(readdata),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .pc(pc), .aluout(aluout), .writedata(writedata)
  );

  always #5 clk = ~clk;

  assign readdata = iord ? mem[aluout[11:2]] : mem[pc[11:2]];

  // unified memory: image reloaded while in reset, stores and IR latch otherwise
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
    end else begin
      if (memwrite) mem[aluout[11:2]] <= writedata;
      if (irwrite)  instr <= mem[pc[11:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  task automatic put(input logic [31:0] w);
    ref_mem[wp] = w;
    wp++;
  endtask

  function automatic logic [4:0] rreg();
    return 5'($urandom_range(0, 9));
  endfunction

  task automatic put_random();
    logic [5:0] fl [6];
    logic [5:0] ul [3];
    logic [4:0] rs, rt;
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
    ul = '{6'h01, 6'h3F, 6'h10};
    rs = rreg();
    rt = rreg();
    case ($urandom_range(0, 9))
      0:       put(enc_i(6'h08, rs, rt, 16'($urandom)));
      1, 2:    put(enc_r(rs, rt, rreg(), fl[$urandom_range(0, 5)]));
      3:       put(enc_i(6'h23, 5'd0, rt, 16'(32'h400 + 4 * $urandom_range(0, 63))));
      4:       put(enc_i(6'h2B, 5'd0, rt, 16'(32'h400 + 4 * $urandom_range(0, 63))));
      5:       put(enc_i(6'h04, rs, ($urandom_range(0, 1) == 0) ? rs : rt, 16'($urandom_range(0, 2))));
      6:       put(enc_i(6'h05, rs, ($urandom_range(0, 1) == 0) ? rs : rt, 16'($urandom_range(0, 2))));
      7:       put(enc_i(6'h0C, rs, rt, 16'($urandom)));
      8:       put(enc_i(6'h0D, rs, rt, 16'($urandom)));
      default: put(enc_i(ul[$urandom_range(0, 2)], rs, rt, 16'($urandom)));
    endcase
  endtask

  // Reference model: execute one instruction at ref_pc, report its cycle count,
  // any store it makes and whether it reads data memory.
  task automatic ref_step(output int cpi, output bit st, output logic [31:0] sa,
                          output logic [31:0] sd, output bit ld);
    logic [31:0] w, a, b, simm, zimm, npc, res, addr;
    logic [5:0]  op;
    logic [4:0]  dst;
    bit          wr;
    w    = ref_mem[ref_pc[11:2]];
    op   = w[31:26];
    a    = ref_reg[w[25:21]];
    b    = ref_reg[w[20:16]];
    simm = {{16{w[15]}}, w[15:0]};
    zimm = {16'd0, w[15:0]};
    npc  = ref_pc + 32'd4;
    addr = a + simm;
    res  = 32'd0;
    dst  = w[20:16];
    wr   = 1'b0;
    st   = 1'b0;
    ld   = 1'b0;
    sa   = 32'd0;
    sd   = 32'd0;
    case (op)
      6'h00: begin
        cpi = 4; wr = 1'b1; dst = w[15:11];
        case (w[5:0])
          6'h22:   res = a - b;
          6'h24:   res = a & b;
          6'h25:   res = a | b;
          6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: res = a + b;
        endcase
      end
      6'h23: begin cpi = 5; ld = 1'b1; wr = 1'b1; res = ref_mem[addr[11:2]]; end
      6'h2B: begin cpi = 4; st = 1'b1; sa = addr; sd = b; ref_mem[addr[11:2]] = b; end
      6'h04: begin cpi = 3; if (a == b) npc = npc + (simm << 2); end
      6'h08: begin cpi = 4; wr = 1'b1; res = a + simm; end
      6'h02: begin cpi = 3; npc = {npc[31:28], w[25:0], 2'b00}; end
`ifdef MIPS_EXT_OPS_EN
      6'h05: begin cpi = 3; if (a != b) npc = npc + (simm << 2); end
      6'h0C: begin cpi = 4; wr = 1'b1; res = a & zimm; end
      6'h0D: begin cpi = 4; wr = 1'b1; res = a | zimm; end
`endif
      default: cpi = 2;
    endcase
    if (wr && dst != 5'd0) ref_reg[dst] = res;
    ref_pc = npc;
  endtask

  initial begin
    int cpi, cyc, n, bad;
    bit st, ld, done;
    logic [31:0] sa, sd, ipc;

    for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
    wp = 0;
    put(enc_i(6'h08, 5'd0, 5'd2, 16'd5));       // 0x00 addi $2,$0,5
    put(enc_i(6'h08, 5'd0, 5'd3, 16'd12));      // 0x04 addi $3,$0,12
    put(enc_r(5'd2, 5'd3, 5'd4, 6'h20));        // 0x08 add $4,$2,$3
    put(enc_i(6'h2B, 5'd0, 5'd4, 16'd84));      // 0x0C sw $4,84($0)
    put(enc_i(6'h23, 5'd0, 5'd5, 16'd84));      // 0x10 lw $5,84($0)
    put(enc_r(5'd3, 5'd2, 5'd6, 6'h2A));        // 0x14 slt $6,$3,$2
    put(enc_r(5'd2, 5'd3, 5'd7, 6'h22));        // 0x18 sub $7,$2,$3
    put(enc_i(6'h04, 5'd2, 5'd3, 16'd5));       // 0x1C beq not taken
    put(enc_i(6'h04, 5'd2, 5'd2, 16'd2));       // 0x20 beq taken -> 0x2C
    put(enc_i(6'h08, 5'd0, 5'd9, 16'd1));
    put(enc_i(6'h08, 5'd0, 5'd9, 16'd2));
    put(enc_i(6'h08, 5'd0, 5'd0, 16'd7));       // 0x2C addi $0,$0,7
    put({6'h02, 26'h10});                       // 0x30 j -> 0x40
    for (int i = 0; i < 3; i++) put(enc_i(6'h08, 5'd0, 5'd9, 16'd3));
    put(enc_i(6'h0D, 5'd0, 5'd8, 16'hFFFF));    // 0x40 ori $8,$0,0xFFFF
    put(enc_i(6'h2B, 5'd0, 5'd0, 16'd88));
    put(enc_i(6'h2B, 5'd0, 5'd5, 16'd92));
    put(enc_i(6'h2B, 5'd0, 5'd6, 16'd96));
    put({6'h02, 26'h20});                       // 0x50 j -> 0x80 over data words
    wp = 32;
    put(enc_i(6'h2B, 5'd0, 5'd7, 16'd100));
    put(enc_i(6'h2B, 5'd0, 5'd8, 16'd104));
    for (int i = 0; i < 48; i++) put_random();
    for (int r = 1; r < 10; r++) put(enc_i(6'h2B, 5'd0, 5'(r), 16'(32'h300 + 4 * r)));
    end_pc = 32'(wp * 4);

    // reset state, then a short run interrupted by an asynchronous mid-cycle reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_pc", pc, 32'd0);
    check("reset_ctl", {29'd0, irwrite, iord, memwrite}, 32'b100);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("midreset_pc", pc, 32'd0);
    check("midreset_ctl", {29'd0, irwrite, iord, memwrite}, 32'b100);
    check("midreset_aluout", aluout, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) ref_reg[i] = 32'd0;
    ref_pc = 32'd0;
    n = 0;
    while (ref_pc != end_pc && n < 300) begin
      ipc = ref_pc;
      check($sformatf("pc_at_fetch_%0h", ipc), pc, ipc);
      check($sformatf("fetch_ctl_%0h", ipc), {29'd0, irwrite, iord, memwrite}, 32'b100);
      ref_step(cpi, st, sa, sd, ld);
      cyc = 1;
      done = 1'b0;
      while (!done && cyc < 10) begin
        @(posedge clk);
        @(negedge clk);
        if (irwrite) begin
          done = 1'b1;
        end else begin
          cyc++;
          check($sformatf("memctl_%0h_c%0d", ipc, cyc), {30'd0, iord, memwrite},
                {30'd0, (ld || st) && cyc == 4, st && cyc == 4});
          if (st && cyc == 4) begin
            check($sformatf("store_addr_%0h", ipc), aluout, sa);
            check($sformatf("store_data_%0h", ipc), writedata, sd);
          end
        end
      end
      check($sformatf("cycles_%0h", ipc), 32'(cyc), 32'(cpi));
      n++;
    end

    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("memory_image", 32'(bad), 32'd0);
    check("sum_store_0x54", mem[21], 32'h11);
    check("lw_result_5", mem[23], 32'h11);
    check("slt_result_6", mem[24], 32'd0);
    check("sub_result_7", mem[25], 32'hFFFFFFF9);
    check("zero_reg_store", mem[22], 32'd0);
`ifdef MIPS_EXT_OPS_EN
    check("ori_result_8", mem[26], 32'h0000FFFF);
`else
    check("ori_nop_result_8", mem[26], 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
